dnn_norm_stream: RTL and testbench

- Parametrised streaming feature normaliser; successor to the fixed 12-element, 26-to-13-bit DNN normaliser.
- Sits between the feature front-end and the DNN input layer.
- Per element k of each frame: vec_o = sat(round(((x - mean[k]) * scale[k]) >>> SHIFT)).
- Adds run-time loadable per-index coefficients, bypass mode, saturation flag, last-element marker and partial-frame detection.

---
 rtl/dnn_norm_pkg.sv | 22 ++
 rtl/dnn_norm_stream_if.sv | 32 +++
 rtl/dnn_norm_coef_rf.sv | 46 ++++
 rtl/dnn_norm_stream.sv | 124 ++++++++++++
 tb/tb_dnn_norm_stream.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/dnn_norm_pkg.sv
// Shared defaults and constant helpers for the streaming feature normaliser.
package dnn_norm_pkg;
  localparam int DEF_IN_W    = 26;
  localparam int DEF_OUT_W   = 13;
  localparam int DEF_VEC_LEN = 12;
  localparam int DEF_COEF_W  = 16;
  localparam int DEF_SHIFT   = 14;
  localparam int DEF_IDX_W   = 8;

  function automatic longint clip_hi(input int out_w);
    return (64'sd1 <<< (out_w - 1)) - 64'sd1;
  endfunction

  function automatic longint clip_lo(input int out_w);
    return -(64'sd1 <<< (out_w - 1));
  endfunction

  // Half-LSB of the scaled product, added before the arithmetic shift (round half up).
  function automatic longint rnd_const(input int shift);
    return 64'sd1 <<< (shift - 1);
  endfunction
endpackage

// File: rtl/dnn_norm_stream_if.sv
// Sample stream, coefficient write port and status outputs of the normaliser.
interface dnn_norm_stream_if
  import dnn_norm_pkg::*;
#(
  parameter int IN_W   = DEF_IN_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int IDX_W  = DEF_IDX_W
);
  logic                     dv_i;
  logic signed [IN_W-1:0]   vec_i;
  logic                     mode_i;
  logic                     coef_we_i;
  logic [IDX_W-1:0]         coef_addr_i;
  logic signed [IN_W-1:0]   coef_mean_i;
  logic signed [COEF_W-1:0] coef_scale_i;
  logic                     dv_o;
  logic signed [OUT_W-1:0]  vec_o;
  logic [IDX_W-1:0]         index_o;
  logic                     last_o;
  logic                     sat_o;
  logic                     partial_o;

  modport master (
    output dv_i, vec_i, mode_i, coef_we_i, coef_addr_i, coef_mean_i, coef_scale_i,
    input  dv_o, vec_o, index_o, last_o, sat_o, partial_o
  );
  modport slave (
    input  dv_i, vec_i, mode_i, coef_we_i, coef_addr_i, coef_mean_i, coef_scale_i,
    output dv_o, vec_o, index_o, last_o, sat_o, partial_o
  );
endinterface

// File: rtl/dnn_norm_coef_rf.sv
// Per-index {mean, scale} register file: one write port, one combinational read port.
module dnn_norm_coef_rf
  import dnn_norm_pkg::*;
#(
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int IN_W    = DEF_IN_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         waddr,
  input  logic signed [IN_W-1:0]   wmean,
  input  logic signed [COEF_W-1:0] wscale,
  input  logic [IDX_W-1:0]         raddr,
  output logic signed [IN_W-1:0]   rmean,
  output logic signed [COEF_W-1:0] rscale
);
  localparam int EW = IN_W + COEF_W;
  // Identity entry: mean 0 in the upper field, unity scale in the lower field.
  localparam logic [EW-1:0] RST_ENT = EW'(1) << SHIFT;

  logic [VEC_LEN-1:0][EW-1:0] rf_q;
  logic [EW-1:0]              rd_ent;

  // Addresses at or beyond VEC_LEN match no entry, so such writes drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < VEC_LEN; i++) rf_q[i] <= RST_ENT;
    end else if (we) begin
      for (int i = 0; i < VEC_LEN; i++)
        if (waddr == IDX_W'(i)) rf_q[i] <= {wmean, wscale};
    end
  end

  always_comb begin
    rd_ent = '0;
    for (int i = 0; i < VEC_LEN; i++)
      if (raddr == IDX_W'(i)) rd_ent = rf_q[i];
  end

  assign rmean  = $signed(rd_ent[COEF_W +: IN_W]);
  assign rscale = $signed(rd_ent[COEF_W-1:0]);
endmodule

// File: rtl/dnn_norm_stream.sv
// Streaming per-element normaliser: index counter, 3-stage subtract/multiply/round-clip
// datapath, and frame flags (last, sat, partial).
module dnn_norm_stream
  import dnn_norm_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int VEC_LEN = DEF_VEC_LEN,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int SHIFT   = DEF_SHIFT,
  parameter int IDX_W   = DEF_IDX_W
) (
  input logic             clk,
  input logic             rst_n,
  dnn_norm_stream_if.slave bus
);
  localparam int STAGES = 3;
  localparam int DW     = IN_W + 1;
  localparam int PW     = IN_W + 1 + COEF_W;
  localparam logic signed [PW-1:0]     RND      = PW'(rnd_const(SHIFT));
  localparam logic signed [PW-1:0]     HI       = PW'(clip_hi(OUT_W));
  localparam logic signed [PW-1:0]     LO       = PW'(clip_lo(OUT_W));
  localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(VEC_LEN - 1);
  localparam logic signed [COEF_W-1:0] UNITY    = COEF_W'(1) << SHIFT;

  logic [IDX_W-1:0]         idx_q;
  logic [STAGES:0]          vld_pipe;
  logic signed [IN_W-1:0]   rf_mean, mean_s;
  logic signed [COEF_W-1:0] rf_scale, scale_s;

  logic signed [DW-1:0]     diff_q;
  logic signed [COEF_W-1:0] scale_q;
  logic [IDX_W-1:0]         idx1_q, idx2_q;
  logic signed [PW-1:0]     prod_q;

  logic signed [PW-1:0]     sum_c, shr_c;
  logic                     over_c, under_c;
  logic signed [OUT_W-1:0]  clip_c;

  logic signed [OUT_W-1:0]  vec_q;
  logic [IDX_W-1:0]         index_q;
  logic                     last_q, sat_q;

  dnn_norm_coef_rf #(
    .VEC_LEN(VEC_LEN), .IN_W(IN_W), .COEF_W(COEF_W), .SHIFT(SHIFT), .IDX_W(IDX_W)
  ) u_coef_rf (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (bus.coef_we_i),
    .waddr  (bus.coef_addr_i),
    .wmean  (bus.coef_mean_i),
    .wscale (bus.coef_scale_i),
    .raddr  (idx_q),
    .rmean  (rf_mean),
    .rscale (rf_scale)
  );

  // Any idle cycle mid-frame aborts the frame; the counter restarts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          idx_q <= '0;
    else if (bus.dv_i && idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
    else                                 idx_q <= '0;
  end

  assign bus.partial_o = ~bus.dv_i & (idx_q != '0);

  // Bypass behaves as identity coefficients, selected per sample.
  assign mean_s  = bus.mode_i ? rf_mean  : '0;
  assign scale_s = bus.mode_i ? rf_scale : UNITY;
  assign vld_pipe[0] = bus.dv_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe[STAGES:1] <= '0;
      diff_q  <= '0;
      scale_q <= '0;
      idx1_q  <= '0;
      prod_q  <= '0;
      idx2_q  <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (vld_pipe[0]) begin
        diff_q  <= {bus.vec_i[IN_W-1], bus.vec_i} - {mean_s[IN_W-1], mean_s};
        scale_q <= scale_s;
        idx1_q  <= idx_q;
      end
      if (vld_pipe[1]) begin
        prod_q <= {{COEF_W{diff_q[DW-1]}}, diff_q} * {{DW{scale_q[COEF_W-1]}}, scale_q};
        idx2_q <= idx1_q;
      end
    end
  end

  always_comb begin
    sum_c   = prod_q + RND;
    shr_c   = sum_c >>> SHIFT;
    over_c  = shr_c > HI;
    under_c = shr_c < LO;
    clip_c  = shr_c[OUT_W-1:0];
    if (over_c)  clip_c = HI[OUT_W-1:0];
    if (under_c) clip_c = LO[OUT_W-1:0];
  end

  // vec_o holds between samples; the side-band flags fall to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q   <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      if (vld_pipe[2]) vec_q <= clip_c;
      index_q <= vld_pipe[2] ? idx2_q : '0;
      last_q  <= vld_pipe[2] & (idx2_q == LAST_IDX);
      sat_q   <= vld_pipe[2] & (over_c | under_c);
    end
  end

  assign bus.dv_o    = vld_pipe[STAGES];
  assign bus.vec_o   = vec_q;
  assign bus.index_o = index_q;
  assign bus.last_o  = last_q;
  assign bus.sat_o   = sat_q;
endmodule

// File: tb/tb_dnn_norm_stream.sv
// Scoreboard bench for dnn_norm_stream at default parameters.
module tb_dnn_norm_stream;
  typedef struct {
    longint vec;
    int     idx;
    bit     last;
    bit     sat;
    int     cyc;
  } exp_t;

  logic   clk;
  logic   rst_n;
  int     cyc;
  int     n_chk;
  int     n_err;
  exp_t   sb[$];
  exp_t   mon_e;
  bit     exp_partial;
  longint m_mean[12];
  longint m_scale[12];
  int     m_idx;
  longint fx[12];

  dnn_norm_stream_if bus();

  dnn_norm_stream dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s act=%0d exp=%0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic model_rst();
    for (int k = 0; k < 12; k++) begin
      m_mean[k]  = 0;
      m_scale[k] = 16384;
    end
    m_idx = 0;
  endtask

  // One cycle of stimulus; the expected output is queued from the pre-write coefficients.
  task automatic drive(input bit dv, input longint x, input bit mode,
                       input bit we, input int addr, input longint mean, input longint scale);
    longint mn, sc, r;
    bit     s;
    @(posedge clk);
    #1;
    bus.dv_i         = dv;
    bus.vec_i        = x[25:0];
    bus.mode_i       = mode;
    bus.coef_we_i    = we;
    bus.coef_addr_i  = addr[7:0];
    bus.coef_mean_i  = mean[25:0];
    bus.coef_scale_i = scale[15:0];
    exp_partial      = !dv && (m_idx != 0);
    if (dv) begin
      mn = mode ? m_mean[m_idx]  : 0;
      sc = mode ? m_scale[m_idx] : 16384;
      r  = ((x - mn) * sc + 8192) >>> 14;
      s  = 0;
      if (r > 4095)       begin r = 4095;  s = 1; end
      else if (r < -4096) begin r = -4096; s = 1; end
      sb.push_back('{vec: r, idx: m_idx, last: (m_idx == 11), sat: s, cyc: cyc});
      m_idx = (m_idx == 11) ? 0 : m_idx + 1;
    end else begin
      m_idx = 0;
    end
    if (we && addr < 12) begin
      m_mean[addr]  = mean;
      m_scale[addr] = scale;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic send_frame(input bit mode);
    for (int i = 0; i < 12; i++) drive(1, fx[i], mode, 0, 0, 0, 0);
  endtask

  task automatic wr(input int addr, input longint mean, input longint scale);
    drive(0, 0, 1, 1, addr, mean, scale);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #2;
    bus.dv_i      = 0;
    bus.coef_we_i = 0;
    rst_n         = 0;
    #1;
    chk("rst_mid_dv",  bus.dv_o, 0);
    chk("rst_mid_vec", bus.vec_o, 0);
    chk("rst_mid_idx", bus.index_o, 0);
    sb.delete();
    model_rst();
    exp_partial = 0;
    @(negedge clk);
    #1;
    rst_n = 1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("partial", bus.partial_o, exp_partial);
      if (bus.dv_o) begin
        if (sb.size() == 0) chk("unexp_dv", bus.dv_o, 0);
        else begin
          mon_e = sb.pop_front();
          chk("vec",  bus.vec_o, mon_e.vec);
          chk("idx",  bus.index_o, mon_e.idx);
          chk("last", bus.last_o, mon_e.last);
          chk("sat",  bus.sat_o, mon_e.sat);
          chk("lat",  cyc - mon_e.cyc, 3);
        end
      end else begin
        chk("sat_idle",  bus.sat_o, 0);
        chk("last_idle", bus.last_o, 0);
        if (sb.size() > 0 && cyc - sb[0].cyc >= 3) begin
          chk("dv_missing", bus.dv_o, 1);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst_n = 0;
    exp_partial = 0;
    bus.dv_i = 0; bus.vec_i = '0; bus.mode_i = 1; bus.coef_we_i = 0;
    bus.coef_addr_i = '0; bus.coef_mean_i = '0; bus.coef_scale_i = '0;
    model_rst();
    #1;
    chk("rst_dv",      bus.dv_o, 0);
    chk("rst_vec",     bus.vec_o, 0);
    chk("rst_idx",     bus.index_o, 0);
    chk("rst_last",    bus.last_o, 0);
    chk("rst_sat",     bus.sat_o, 0);
    chk("rst_partial", bus.partial_o, 0);
    #20;
    @(negedge clk);
    rst_n = 1;

    // identity coefficients, clipping at both rails
    fx = '{-14237, 2768, 4095, 4096, -4097, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1);
    idle(4);

    // scale 1024 everywhere, then a mean that cancels element 0
    for (int k = 0; k < 12; k++) wr(k, 0, 1024);
    fx = '{-71483, -14237, -68960, 155254, 100, -100, 5000, 0, 0, 0, 0, 1};
    send_frame(1);
    wr(0, -71483, 1024);
    send_frame(1);
    idle(2);

    // rounding on half-LSB boundaries
    for (int k = 0; k < 3; k++) wr(k, 0, 8192);
    fx = '{3, -3, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(1);

    // aborted frame, then back-to-back complete frames
    for (int i = 0; i < 5; i++) drive(1, 1000 * i, 1, 0, 0, 0, 0);
    idle(1);
    fx = '{11, 22, 33, 44, 55, 66, 77, 88, 99, 111, 122, 133};
    send_frame(1);
    send_frame(1);
    idle(3);

    // bypass with non-identity coefficients, switching to normalise mid-frame
    wr(1, 500, -3000);
    for (int i = 0; i < 12; i++) drive(1, (i == 0) ? 2768 : 2768 + 7 * i, (i >= 2), 0, 0, 0, 0);
    idle(2);

    // write colliding with the sample of the same index; out-of-range write
    for (int i = 0; i < 12; i++)
      drive(1, 4000 + i, 1, (i == 2), 2, 300, 6000);
    send_frame(1);
    wr(12, 777, -5);
    send_frame(1);

    // reset mid-frame: in-flight samples dropped, coefficients back to identity
    for (int i = 0; i < 7; i++) drive(1, 100 * i - 300, 1, 0, 0, 0, 0);
    pulse_reset();
    fx = '{-14237, 2768, 4095, 4096, -4097, 17, -17, 0, 1, -1, 9, 100};
    send_frame(1);

    // randomized traffic with gaps, mode flips and coefficient writes
    for (int i = 0; i < 300; i++) begin
      logic [15:0] rs;
      rs = 16'($urandom);
      drive(($urandom % 8) != 0,
            longint'($urandom_range(600000)) - 300000,
            ($urandom % 4) != 0,
            ($urandom % 4) == 0,
            int'($urandom_range(13)),
            longint'($urandom_range(200000)) - 100000,
            longint'($signed(rs)));
    end
    idle(8);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
